param_ring_fifo: RTL and testbench

Parametrised successor to the team's 8-deep byte circular buffer: a single-clock ring FIFO with configurable data width and depth. Depth need not be a power of two. Adds programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and defined full-with-read pass-through. Sits between producer and consumer stages in the same clock domain; read side is show-ahead.

---
 rtl/param_ring_fifo_pkg.sv | 14 +
 rtl/param_ring_fifo_ptr.sv | 32 +++
 rtl/param_ring_fifo.sv | 106 ++++++++++
 tb/tb_param_ring_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_ring_fifo_pkg.sv
// Shared width helpers for the parametrised ring FIFO.
package param_ring_fifo_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: indexes 0..depth-1, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/param_ring_fifo_ptr.sv
// Wrapping pointer for a ring of arbitrary (non power-of-two) depth.
module ring_ptr
  import param_ring_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  // Explicit compare-and-wrap so the pointer never holds a value >= DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (adv) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/param_ring_fifo.sv
// Single-clock show-ahead ring FIFO with threshold flags and sticky errors.
module param_ring_fifo
  import param_ring_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  localparam int unsigned CW = cnt_width(DEPTH),
  localparam int unsigned PW = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         counter,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_rd_do;
  logic                  w_wr_do;

  // Acceptance: a read never falls through a same-cycle write; a write to a
  // full ring is taken only when a read frees the slot in the same cycle.
  assign w_rd_acc = read_enable && !empty;
  assign w_wr_acc = write_enable && (!full || w_rd_acc);
  assign w_rd_do  = w_rd_acc && !flush;
  assign w_wr_do  = w_wr_acc && !flush;

  ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .adv   (w_wr_do),
    .ptr   (w_wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .adv   (w_rd_do),
    .ptr   (w_rd_ptr)
  );

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_do) begin
      r_mem[w_wr_ptr] <= write_data;
    end
  end

  // Occupancy: simultaneous accepted read and write leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Sticky error flags; clear_errors wins over a same-cycle new error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_errors) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (write_enable && !w_wr_acc && !flush);
      r_underflow <= r_underflow | (read_enable  && !w_rd_acc && !flush);
    end
  end

  assign read_data    = r_mem[w_rd_ptr];
  assign counter      = r_count;
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_ring_fifo.sv
// Directed bench: depth-8 instance with custom thresholds, depth-6 instance.
module tb_param_ring_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_fl, a_we, a_re, a_ce;
  logic [7:0] a_wd, a_rd;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_cnt;

  logic       b_fl, b_we, b_re, b_ce;
  logic [7:0] b_wd, b_rd;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;

  int checks = 0;
  int errors = 0;

  param_ring_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .write_enable(a_we), .write_data(a_wd),
    .read_enable(a_re), .read_data(a_rd), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .counter(a_cnt), .overflow(a_ovf),
    .underflow(a_unf), .clear_errors(a_ce)
  );

  param_ring_fifo #(.DATA_WIDTH(8), .DEPTH(6)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .write_enable(b_we), .write_data(b_wd),
    .read_enable(b_re), .read_data(b_rd), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .counter(b_cnt), .overflow(b_ovf),
    .underflow(b_unf), .clear_errors(b_ce)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_fl = 0; a_we = 0; a_re = 0; a_ce = 0; a_wd = '0;
    b_fl = 0; b_we = 0; b_re = 0; b_ce = 0; b_wd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full",  32'(a_full),  0);
    chk("rst_ae",    32'(a_ae),    1);
    chk("rst_af",    32'(a_af),    0);
    chk("rst_cnt",   32'(a_cnt),   0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_unf",   32'(a_unf),   0);
    rst_n = 1'b1;

    // Fill 0x01..0x08, tracking thresholds AE=2, AF=6.
    for (int k = 1; k <= 8; k++) begin
      a_we = 1; a_wd = 8'(k);
      cyc();
      chk("fill_cnt", 32'(a_cnt), 32'(k));
      chk("fill_ae",  32'(a_ae),  (k <= 2) ? 1 : 0);
      chk("fill_af",  32'(a_af),  (k >= 6) ? 1 : 0);
      chk("fill_full", 32'(a_full), (k == 8) ? 1 : 0);
    end

    // Write while full with no read: dropped, overflow set.
    a_wd = 8'h09;
    cyc();
    chk("ovf_cnt",  32'(a_cnt),  8);
    chk("ovf_flag", 32'(a_ovf),  1);
    chk("ovf_head", 32'(a_rd),   8'h01);

    a_we = 0; a_ce = 1;
    cyc();
    a_ce = 0;
    chk("clr_ovf", 32'(a_ovf), 0);

    // Full with simultaneous read and write: pass-through.
    a_we = 1; a_re = 1; a_wd = 8'hAA;
    cyc();
    a_we = 0; a_re = 0;
    chk("pt_cnt",  32'(a_cnt),  8);
    chk("pt_full", 32'(a_full), 1);
    chk("pt_ovf",  32'(a_ovf),  0);

    // Drain: 0x02..0x08 then 0xAA.
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(a_rd), (i < 7) ? 32'(i + 2) : 32'h00AA);
      a_re = 1;
      cyc();
    end
    a_re = 0;
    chk("drain_empty", 32'(a_empty), 1);
    chk("drain_cnt",   32'(a_cnt),   0);
    chk("drain_unf",   32'(a_unf),   0);

    // Read on empty.
    a_re = 1;
    cyc();
    chk("unf_flag", 32'(a_unf), 1);
    chk("unf_cnt",  32'(a_cnt), 0);

    // Read+write on empty: write taken, read rejected.
    a_we = 1; a_wd = 8'h55;
    cyc();
    a_we = 0; a_re = 0;
    chk("rw_empty_cnt", 32'(a_cnt),   1);
    chk("rw_empty_unf", 32'(a_unf),   1);
    chk("rw_empty_rd",  32'(a_rd),    8'h55);
    chk("rw_empty_emp", 32'(a_empty), 0);

    a_ce = 1;
    cyc();
    a_ce = 0;
    chk("clr_unf", 32'(a_unf), 0);
    chk("clr_ovf2", 32'(a_ovf), 0);
    chk("clr_cnt", 32'(a_cnt), 1);

    // Bring occupancy to 4, then flush with a simultaneous write.
    a_we = 1;
    a_wd = 8'h66; cyc();
    a_wd = 8'h77; cyc();
    a_wd = 8'h88; cyc();
    chk("pre_flush_cnt", 32'(a_cnt), 4);
    a_fl = 1; a_wd = 8'h99;
    cyc();
    a_fl = 0;
    chk("flush_cnt",   32'(a_cnt),   0);
    chk("flush_empty", 32'(a_empty), 1);
    chk("flush_ovf",   32'(a_ovf),   0);
    chk("flush_unf",   32'(a_unf),   0);

    a_wd = 8'h11;
    cyc();
    a_we = 0;
    chk("post_flush_rd",  32'(a_rd),  8'h11);
    chk("post_flush_cnt", 32'(a_cnt), 1);

    a_re = 1;
    cyc();
    cyc();
    a_re = 0;
    chk("re_unf", 32'(a_unf), 1);
    chk("re_cnt", 32'(a_cnt), 0);

    // Mid-stream reset with a write pending.
    a_we = 1;
    a_wd = 8'h21; cyc();
    a_wd = 8'h22; cyc();
    chk("pre_rst_cnt", 32'(a_cnt), 2);
    rst_n = 1'b0; a_wd = 8'h23;
    cyc();
    chk("mrst_cnt",   32'(a_cnt),   0);
    chk("mrst_empty", 32'(a_empty), 1);
    chk("mrst_full",  32'(a_full),  0);
    chk("mrst_unf",   32'(a_unf),   0);
    chk("mrst_ovf",   32'(a_ovf),   0);
    chk("mrst_ae",    32'(a_ae),    1);
    chk("mrst_af",    32'(a_af),    0);
    rst_n = 1'b1; a_we = 0;
    cyc();
    chk("mrst_hold_cnt", 32'(a_cnt), 0);

    // Error and clear in the same cycle: clear wins.
    a_re = 1; a_ce = 1;
    cyc();
    a_re = 0; a_ce = 0;
    chk("clr_wins", 32'(a_unf), 0);

    // Depth 6: preload 3, then 20 read+write cycles across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      b_we = 1; b_wd = 8'(16 + i);
      cyc();
    end
    b_we = 0;
    chk("b_pre_cnt", 32'(b_cnt), 3);
    for (int i = 0; i < 20; i++) begin
      chk("b_rw_data", 32'(b_rd), 32'(16 + i));
      b_we = 1; b_re = 1; b_wd = 8'(19 + i);
      cyc();
      chk("b_rw_cnt", 32'(b_cnt), 3);
    end
    b_we = 0;
    for (int i = 0; i < 3; i++) begin
      chk("b_drain_data", 32'(b_rd), 32'(36 + i));
      b_re = 1;
      cyc();
    end
    b_re = 0;
    chk("b_empty", 32'(b_empty), 1);
    chk("b_ae", 32'(b_ae), 1);

    // Depth 6: fill to full, default AF threshold is 5.
    for (int i = 0; i < 6; i++) begin
      b_we = 1; b_wd = 8'(8'h40 + i);
      cyc();
      chk("b_fill_af",   32'(b_af),   (i >= 4) ? 1 : 0);
      chk("b_fill_full", 32'(b_full), (i == 5) ? 1 : 0);
    end
    b_we = 0;
    chk("b_fill_cnt", 32'(b_cnt), 6);
    chk("b_fill_rd",  32'(b_rd),  8'h40);
    chk("b_ovf",      32'(b_ovf), 0);
    chk("b_unf",      32'(b_unf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
